video_timing_gen: RTL and testbench

Parametrised raster timing generator and pixel sink for the HDMI transmitter path. It replaces the fixed 720x480 sequencer with run-time-static porch/sync/active parameters, programmable sync polarity, and a pixel-clock-enable input. It also adds a valid/ready pixel handshake, underflow detection and a graceful end-of-frame stop. It sits between the frame-buffer read path and the HDMI output pins.

---
 rtl/video_timing_gen_pkg.sv | 28 ++
 rtl/video_timing_gen_raster_counter.sv | 43 ++++
 rtl/video_timing_gen.sv | 153 +++++++++++++++
 tb/tb_video_timing_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// video_pkg: shared types and default 720x480 timing for the raster generator.
//   region_e  - horizontal/vertical region within a line/frame
//   state_e   - run-control FSM states
//   region_of - maps a counter value onto its region given region lengths
package video_pkg;

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_e;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 62;
    localparam int DEF_H_BP     = 60;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 30;

    // Regions are laid out active, front porch, sync, back porch.
    function automatic region_e region_of(input int cnt, input int act,
                                          input int fp, input int sync);
        if (cnt < act)                 return ACTIVE;
        else if (cnt < act + fp)       return FP;
        else if (cnt < act + fp + sync) return SYNC;
        else                           return BP;
    endfunction

endpackage

// File: rtl/video_timing_gen_raster_counter.sv
// raster_counter: counts 0..MAX-1 on en, wraps to 0.
//   clk, rst (async, active-high)
//   en   - advance request
//   clr  - synchronous clear, overrides en
//   cnt  - current count
//   wrap - high on the enabled cycle where cnt is MAX-1
module raster_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign wrap = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = wrap ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator and pixel sink for the HDMI path.
//   clk, rst (async, active-high), pix_ce (pixel-rate enable)
//   en          - run request; dropping it finishes the current frame then idles
//   err_clr     - clears sticky underflow
//   data/data_valid/rdy - upstream pixel handshake, rdy is combinational
//   HDMI_*      - registered pixel, data enable and syncs
//   frame_start/line_start - one-clk pulses with first active pixel of frame/line
//   underflow   - sticky: an active pixel found no valid data
//   h_pos/v_pos - raster counters
module video_timing_gen
    import video_pkg::*;
#(
    parameter int                DATA_W   = 36,
    parameter int                H_ACTIVE = DEF_H_ACTIVE,
    parameter int                H_FP     = DEF_H_FP,
    parameter int                H_SYNC   = DEF_H_SYNC,
    parameter int                H_BP     = DEF_H_BP,
    parameter int                V_ACTIVE = DEF_V_ACTIVE,
    parameter int                V_FP     = DEF_V_FP,
    parameter int                V_SYNC   = DEF_V_SYNC,
    parameter int                V_BP     = DEF_V_BP,
    parameter logic              HS_POL   = 1'b1,
    parameter logic              VS_POL   = 1'b1,
    parameter logic [DATA_W-1:0] FILL     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_ce,
    input  logic              en,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              rdy,
    output logic [DATA_W-1:0] HDMI_DATA,
    output logic              HDMI_EN,
    output logic              HDMI_HSYNC,
    output logic              HDMI_VSYNC,
    output logic              frame_start,
    output logic              line_start,
    output logic              underflow,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] h_pos,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] v_pos
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    state_e            state_q;
    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              h_wrap;
    logic              v_wrap;   // last pixel of the frame on a tick
    logic              running;
    logic              tick;
    logic              active;
    region_e           h_reg;
    region_e           v_reg;

    logic [DATA_W-1:0] hdmi_data_q;
    logic              hdmi_en_q;
    logic              hdmi_hs_q;
    logic              hdmi_vs_q;
    logic              frame_start_q;
    logic              line_start_q;
    logic              underflow_q;

    assign running = (state_q != IDLE);
    assign tick    = running && pix_ce;

    // Counters sit at 0 while idle so the first tick after start is (0,0).
    raster_counter #(.MAX(H_TOTAL), .W(HW)) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (tick),
        .clr  (!running),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    raster_counter #(.MAX(V_TOTAL), .W(VW)) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (h_wrap),
        .clr  (!running),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    assign h_reg  = region_of(int'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
    assign v_reg  = region_of(int'(v_cnt), V_ACTIVE, V_FP, V_SYNC);
    assign active = (h_reg == ACTIVE) && (v_reg == ACTIVE);
    assign rdy    = tick && active && data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hdmi_data_q   <= '0;
            hdmi_en_q     <= 1'b0;
            hdmi_hs_q     <= ~HS_POL;
            hdmi_vs_q     <= ~VS_POL;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE:    if (en) state_q <= RUN;
                RUN:     if (!en) state_q <= STOP;
                // Only leave at the frame boundary so a frame is never cut short.
                STOP:    if (en) state_q <= RUN;
                         else if (v_wrap) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (pix_ce) begin
                if (running) begin
                    hdmi_en_q   <= active;
                    // Underflow keeps timing: the slot still goes out, filled.
                    hdmi_data_q <= !active ? '0 : (data_valid ? data : FILL);
                    hdmi_hs_q   <= (h_reg == SYNC) ? HS_POL : ~HS_POL;
                    hdmi_vs_q   <= (v_reg == SYNC) ? VS_POL : ~VS_POL;
                end else begin
                    hdmi_en_q   <= 1'b0;
                    hdmi_data_q <= '0;
                    hdmi_hs_q   <= ~HS_POL;
                    hdmi_vs_q   <= ~VS_POL;
                end
            end

            // Pulses are computed every clk so they drop after one cycle.
            frame_start_q <= tick && (h_cnt == '0) && (v_cnt == '0);
            line_start_q  <= tick && (h_cnt == '0) && (v_reg == ACTIVE);

            // A new underflow beats a simultaneous clear.
            if (tick && active && !data_valid)
                underflow_q <= 1'b1;
            else if (err_clr)
                underflow_q <= 1'b0;
        end
    end

    assign HDMI_DATA   = hdmi_data_q;
    assign HDMI_EN     = hdmi_en_q;
    assign HDMI_HSYNC  = hdmi_hs_q;
    assign HDMI_VSYNC  = hdmi_vs_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign underflow   = underflow_q;
    assign h_pos       = h_cnt;
    assign v_pos       = v_cnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench on an 8x6 raster (H 4/1/2/1, V 3/1/1/1), pix_ce every 2nd clk.
// dut_a: positive syncs, FILL=AA; dut_b: negative syncs, FILL=55, same inputs.
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_ce = 1'b0;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data = '0;
    logic       data_valid = 1'b0;

    logic       rdy_a, en_a, hs_a, vs_a, fs_a, ls_a, uf_a;
    logic [7:0] dat_a;
    logic [2:0] hp_a, vp_a;
    logic       rdy_b, en_b, hs_b, vs_b, fs_b, ls_b, uf_b;
    logic [7:0] dat_b;
    logic [2:0] hp_b, vp_b;

    int n_chk = 0;
    int n_bad = 0;
    int fs_hi = 0, fs_rise = 0, ls_hi = 0, ls_rise = 0, rdy_bad = 0;
    logic fs_prev = 1'b0, ls_prev = 1'b0;

    // Hand tables: bit index = h or v.
    logic [7:0] en_h  = 8'b0000_1111;
    logic [5:0] en_v  = 6'b00_0111;
    logic [7:0] hs_tb = 8'b0110_0000;
    logic [5:0] vs_tb = 6'b01_0000;

    always #5 clk = ~clk;

    video_timing_gen #(
        .DATA_W(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .FILL(8'hAA)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .err_clr(err_clr),
        .data(data), .data_valid(data_valid), .rdy(rdy_a),
        .HDMI_DATA(dat_a), .HDMI_EN(en_a), .HDMI_HSYNC(hs_a), .HDMI_VSYNC(vs_a),
        .frame_start(fs_a), .line_start(ls_a), .underflow(uf_a),
        .h_pos(hp_a), .v_pos(vp_a)
    );

    video_timing_gen #(
        .DATA_W(8), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FILL(8'h55)
    ) dut_b (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en), .err_clr(err_clr),
        .data(data), .data_valid(data_valid), .rdy(rdy_b),
        .HDMI_DATA(dat_b), .HDMI_EN(en_b), .HDMI_HSYNC(hs_b), .HDMI_VSYNC(vs_b),
        .frame_start(fs_b), .line_start(ls_b), .underflow(uf_b),
        .h_pos(hp_b), .v_pos(vp_b)
    );

    always @(negedge clk) begin
        fs_hi   += int'(fs_a);
        ls_hi   += int'(ls_a);
        fs_rise += int'(fs_a && !fs_prev);
        ls_rise += int'(ls_a && !ls_prev);
        fs_prev  = fs_a;
        ls_prev  = ls_a;
        if ((rdy_a || rdy_b) && !pix_ce) rdy_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_en"},   32'(en_a),  32'(1'b0));
        chk({tag, "_hs_a"}, 32'(hs_a),  32'(1'b0));
        chk({tag, "_hs_b"}, 32'(hs_b),  32'(1'b1));
        chk({tag, "_vs_a"}, 32'(vs_a),  32'(1'b0));
        chk({tag, "_vs_b"}, 32'(vs_b),  32'(1'b1));
        chk({tag, "_hpos"}, 32'(hp_a),  32'(0));
        chk({tag, "_vpos"}, 32'(vp_a),  32'(0));
    endtask

    // One frame of pixels. uf_*: pixel with data_valid=0 (mode 1: clear
    // afterwards, mode 2: err_clr on the same clk). dr_*: pixel where en drops.
    // rs_*: pixel where rst is asserted and the frame is abandoned.
    task automatic run_frame(input int uf_h, input int uf_v, input int uf_mode,
                             input int dr_h, input int dr_v,
                             input int rs_h, input int rs_v);
        int   fs0, ls0, fsr0, lsr0;
        logic [7:0] k;
        logic act, bad;
        k = 8'd0;
        fs0 = fs_hi; ls0 = ls_hi; fsr0 = fs_rise; lsr0 = ls_rise;
        for (int v = 0; v < 6; v++) begin
            for (int h = 0; h < 8; h++) begin
                act = en_h[h] && en_v[v];
                bad = (h == uf_h) && (v == uf_v);
                if ((h == dr_h) && (v == dr_v)) en = 1'b0;
                chk("h_pos", 32'(hp_a), 32'(h));
                chk("v_pos", 32'(vp_a), 32'(v));
                if ((h == rs_h) && (v == rs_v)) begin
                    rst = 1'b1;
                    #1;
                    chk_idle_out("rst");
                    chk("rst_data", 32'(dat_a), 32'(0));
                    chk("rst_uf",   32'(uf_a),  32'(1'b0));
                    chk("rst_fs",   32'(fs_a),  32'(1'b0));
                    chk("rst_ls",   32'(ls_a),  32'(1'b0));
                    return;
                end
                data       = k;
                data_valid = !bad;
                err_clr    = bad && (uf_mode == 2);
                pix_ce     = 1'b1;
                #1;
                chk("rdy", 32'(rdy_a), 32'(act && !bad));
                @(posedge clk); #1;
                pix_ce  = 1'b0;
                err_clr = 1'b0;
                chk("hdmi_en", 32'(en_a), 32'(act));
                if (act) chk("hdmi_data", 32'(dat_a), 32'(bad ? 8'hAA : k));
                if (act && bad) chk("fill_b", 32'(dat_b), 32'(8'h55));
                chk("hs_a", 32'(hs_a), 32'(hs_tb[h]));
                chk("hs_b", 32'(hs_b), 32'(!hs_tb[h]));
                chk("vs_a", 32'(vs_a), 32'(vs_tb[v]));
                chk("vs_b", 32'(vs_b), 32'(!vs_tb[v]));
                if (bad) chk("uf_set", 32'(uf_a), 32'(1'b1));
                if (act && !bad) k = k + 8'd1;
                if (bad && (uf_mode == 1)) err_clr = 1'b1;
                @(posedge clk); #1;
                if (bad && (uf_mode == 1)) begin
                    err_clr = 1'b0;
                    chk("uf_clr", 32'(uf_a), 32'(1'b0));
                end
            end
        end
        chk("fs_cnt",  32'(fs_hi - fs0),    32'(1));
        chk("fs_rise", 32'(fs_rise - fsr0), 32'(1));
        chk("ls_cnt",  32'(ls_hi - ls0),    32'(3));
        chk("ls_rise", 32'(ls_rise - lsr0), 32'(3));
    endtask

    initial begin
        int fs0;
        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        chk_idle_out("reset");
        chk("reset_data", 32'(dat_a), 32'(0));
        chk("reset_uf",   32'(uf_a),  32'(1'b0));
        chk("reset_fs",   32'(fs_a),  32'(1'b0));
        rst = 1'b0;

        // en=0: raster must not move on pix_ce.
        data_valid = 1'b1;
        pix_ce = 1'b1; #1;
        chk("pre_rdy", 32'(rdy_a), 32'(1'b0));
        @(posedge clk); #1; pix_ce = 1'b0;
        @(posedge clk); #1;
        chk_idle_out("pre");

        // Start: one clk to RUN, then clean frame with data 0..11.
        en = 1'b1;
        @(posedge clk); #1;
        run_frame(-1, -1, 0, -1, -1, -1, -1);

        // Underflow at (2,1), cleared afterwards.
        run_frame(2, 1, 1, -1, -1, -1, -1);

        // en dropped at (1,2): frame completes, then idle.
        run_frame(-1, -1, 0, 1, 2, -1, -1);
        fs0 = fs_hi;
        data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_ce = 1'b1; #1;
            chk("idle_rdy", 32'(rdy_a), 32'(1'b0));
            @(posedge clk); #1; pix_ce = 1'b0;
            chk_idle_out("idle");
            @(posedge clk); #1;
        end
        chk("idle_fs", 32'(fs_hi - fs0), 32'(0));

        // Restart, underflow with simultaneous err_clr, then reset at (3,1).
        en = 1'b1;
        @(posedge clk); #1;
        run_frame(1, 0, 2, -1, -1, 3, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(-1, -1, 0, -1, -1, -1, -1);

        chk("rdy_no_ce", 32'(rdy_bad), 32'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
